// File: rtl/via_pkg.sv
// Shared constants for the reduced 6522-style VIA: register map, IFR bit
// positions and ACR control bit positions.
package via_pkg;

  localparam logic [3:0] VIA_ORB    = 4'h0;
  localparam logic [3:0] VIA_ORA    = 4'h1;
  localparam logic [3:0] VIA_DDRB   = 4'h2;
  localparam logic [3:0] VIA_DDRA   = 4'h3;
  localparam logic [3:0] VIA_T1CL   = 4'h4;
  localparam logic [3:0] VIA_T1CH   = 4'h5;
  localparam logic [3:0] VIA_T1LL   = 4'h6;
  localparam logic [3:0] VIA_T1LH   = 4'h7;
  localparam logic [3:0] VIA_T2CL   = 4'h8;
  localparam logic [3:0] VIA_T2CH   = 4'h9;
  localparam logic [3:0] VIA_SR     = 4'hA;
  localparam logic [3:0] VIA_ACR    = 4'hB;
  localparam logic [3:0] VIA_PCR    = 4'hC;
  localparam logic [3:0] VIA_IFR    = 4'hD;
  localparam logic [3:0] VIA_IER    = 4'hE;
  localparam logic [3:0] VIA_ORA_NH = 4'hF;

  localparam int IFR_T1 = 6;
  localparam int IFR_T2 = 5;

  localparam int ACR_T1_FREERUN = 6;
  localparam int ACR_PB7_EN     = 7;

endpackage

// File: rtl/via_timer16.sv
// 16-bit down counter with reload latch and armed flag; shared by Timer 1
// (free-run capable) and Timer 2 (freerun_i tied low).
module via_timer16 (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        tick_i,
  input  logic        freerun_i,
  input  logic        latch_lo_we_i,
  input  logic        latch_hi_we_i,
  input  logic        start_i,
  input  logic [7:0]  din_i,
  output logic [15:0] count_o,
  output logic [15:0] latch_o,
  output logic        underflow_o
);

  logic [15:0] count_q, count_d;
  logic [15:0] latch_q, latch_d;
  logic        armed_q, armed_d;
  logic        at_zero;

  assign at_zero = (count_q == 16'h0000);

  // A start on the same edge as an underflow wins: no flag is raised.
  assign underflow_o = tick_i & armed_q & at_zero & ~start_i;

  always_comb begin
    count_d = count_q;
    latch_d = latch_q;
    armed_d = armed_q;
    if (latch_lo_we_i) latch_d[7:0]  = din_i;
    if (latch_hi_we_i) latch_d[15:8] = din_i;
    if (start_i) begin
      count_d = {din_i, latch_q[7:0]};
      armed_d = 1'b1;
    end else if (tick_i) begin
      if (at_zero) begin
        if (freerun_i) begin
          count_d = latch_q;
        end else begin
          count_d = 16'hFFFF;
          armed_d = 1'b0;
        end
      end else begin
        count_d = count_q - 16'h0001;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 16'h0000;
      latch_q <= 16'h0000;
      armed_q <= 1'b0;
    end else begin
      count_q <= count_d;
      latch_q <= latch_d;
      armed_q <= armed_d;
    end
  end

  assign count_o = count_q;
  assign latch_o = latch_q;

endmodule

// File: rtl/via_timer_lite.sv
// Reduced 6522-style VIA: ports A/B with DDRs, Timer 1/2, IFR/IER and IRQ.
// Optional macro VIA_PB7_EN lets Timer 1 drive PB7 while ACR7 is set.
module via_timer_lite
  import via_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs,
  input  logic       we,
  input  logic [3:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq_n,
  input  logic [7:0] pa_in,
  output logic [7:0] pa_out,
  output logic [7:0] pa_oe,
  input  logic [7:0] pb_in,
  output logic [7:0] pb_out,
  output logic [7:0] pb_oe
);

  localparam logic [7:0] PRE_LAST = 8'(TICK_DIV - 1);

  logic [7:0] pre_q, pre_d;
  logic       tick;

  logic [7:0] orb_q, orb_d, ora_q, ora_d;
  logic [7:0] ddrb_q, ddrb_d, ddra_q, ddra_d;
  logic [7:0] acr_q, acr_d, pcr_q, pcr_d;
  logic [6:0] ier_q, ier_d;
  logic       ifr_t1_q, ifr_t1_d, ifr_t2_q, ifr_t2_d;
  logic       irq_n_q;
  logic       ifr_irq;

  logic       wr_en, rd_en;
  logic       wr_t1cl, wr_t1ch, wr_t1ll, wr_t1lh, wr_t2cl, wr_t2ch, wr_ifr;
  logic       rd_t1cl, rd_t2cl;
  logic       clr_t1, clr_t2;

  logic [15:0] t1_count, t1_latch, t2_count, t2_latch;
  logic        t1_uf, t2_uf;
  logic        unused_t2;
  logic [7:0]  dout_mux;

  // Free-running prescaler; timer loads never disturb its phase.
  assign tick  = (pre_q == PRE_LAST);
  assign pre_d = tick ? 8'h00 : pre_q + 8'h01;

  assign wr_en   = cs & we;
  assign rd_en   = cs & ~we;
  assign wr_t1cl = wr_en && (addr == VIA_T1CL);
  assign wr_t1ch = wr_en && (addr == VIA_T1CH);
  assign wr_t1ll = wr_en && (addr == VIA_T1LL);
  assign wr_t1lh = wr_en && (addr == VIA_T1LH);
  assign wr_t2cl = wr_en && (addr == VIA_T2CL);
  assign wr_t2ch = wr_en && (addr == VIA_T2CH);
  assign wr_ifr  = wr_en && (addr == VIA_IFR);
  assign rd_t1cl = rd_en && (addr == VIA_T1CL);
  assign rd_t2cl = rd_en && (addr == VIA_T2CL);

  assign clr_t1 = rd_t1cl | wr_t1ch | wr_t1lh | (wr_ifr & din[IFR_T1]);
  assign clr_t2 = rd_t2cl | wr_t2ch | (wr_ifr & din[IFR_T2]);

  via_timer16 u_t1 (
    .clk_i         (clk),
    .rst_ni        (reset_n),
    .tick_i        (tick),
    .freerun_i     (acr_q[ACR_T1_FREERUN]),
    .latch_lo_we_i (wr_t1cl | wr_t1ll),
    .latch_hi_we_i (wr_t1ch | wr_t1lh),
    .start_i       (wr_t1ch),
    .din_i         (din),
    .count_o       (t1_count),
    .latch_o       (t1_latch),
    .underflow_o   (t1_uf)
  );

  via_timer16 u_t2 (
    .clk_i         (clk),
    .rst_ni        (reset_n),
    .tick_i        (tick),
    .freerun_i     (1'b0),
    .latch_lo_we_i (wr_t2cl),
    .latch_hi_we_i (1'b0),
    .start_i       (wr_t2ch),
    .din_i         (din),
    .count_o       (t2_count),
    .latch_o       (t2_latch),
    .underflow_o   (t2_uf)
  );

  // Timer 2's latch only feeds its own counter load.
  assign unused_t2 = ^t2_latch;

  assign ifr_irq = (ifr_t1_q & ier_q[IFR_T1]) | (ifr_t2_q & ier_q[IFR_T2]);

  always_comb begin
    orb_d    = orb_q;
    ora_d    = ora_q;
    ddrb_d   = ddrb_q;
    ddra_d   = ddra_q;
    acr_d    = acr_q;
    pcr_d    = pcr_q;
    ier_d    = ier_q;
    if (wr_en) begin
      case (addr)
        VIA_ORB:             orb_d  = din;
        VIA_ORA, VIA_ORA_NH: ora_d  = din;
        VIA_DDRB:            ddrb_d = din;
        VIA_DDRA:            ddra_d = din;
        VIA_ACR:             acr_d  = din;
        VIA_PCR:             pcr_d  = din;
        VIA_IER:             ier_d  = din[7] ? (ier_q | din[6:0]) : (ier_q & ~din[6:0]);
        default:             ;
      endcase
    end
    // Timer set beats any same-edge clear.
    ifr_t1_d = t1_uf | (ifr_t1_q & ~clr_t1);
    ifr_t2_d = t2_uf | (ifr_t2_q & ~clr_t2);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q    <= 8'h00;
      orb_q    <= 8'h00;
      ora_q    <= 8'h00;
      ddrb_q   <= 8'h00;
      ddra_q   <= 8'h00;
      acr_q    <= 8'h00;
      pcr_q    <= 8'h00;
      ier_q    <= 7'h00;
      ifr_t1_q <= 1'b0;
      ifr_t2_q <= 1'b0;
      irq_n_q  <= 1'b1;
    end else begin
      pre_q    <= pre_d;
      orb_q    <= orb_d;
      ora_q    <= ora_d;
      ddrb_q   <= ddrb_d;
      ddra_q   <= ddra_d;
      acr_q    <= acr_d;
      pcr_q    <= pcr_d;
      ier_q    <= ier_d;
      ifr_t1_q <= ifr_t1_d;
      ifr_t2_q <= ifr_t2_d;
      irq_n_q  <= ~ifr_irq;
    end
  end

  always_comb begin
    dout_mux = 8'h00;
    case (addr)
      VIA_ORB:             dout_mux = (orb_q & ddrb_q) | (pb_in & ~ddrb_q);
      VIA_ORA, VIA_ORA_NH: dout_mux = pa_in;
      VIA_DDRB:            dout_mux = ddrb_q;
      VIA_DDRA:            dout_mux = ddra_q;
      VIA_T1CL:            dout_mux = t1_count[7:0];
      VIA_T1CH:            dout_mux = t1_count[15:8];
      VIA_T1LL:            dout_mux = t1_latch[7:0];
      VIA_T1LH:            dout_mux = t1_latch[15:8];
      VIA_T2CL:            dout_mux = t2_count[7:0];
      VIA_T2CH:            dout_mux = t2_count[15:8];
      VIA_SR:              dout_mux = 8'h00;
      VIA_ACR:             dout_mux = acr_q;
      VIA_PCR:             dout_mux = pcr_q;
      VIA_IFR:             dout_mux = {ifr_irq, ifr_t1_q, ifr_t2_q, 5'b00000};
      VIA_IER:             dout_mux = {1'b1, ier_q};
      default:             dout_mux = 8'h00;
    endcase
  end

  assign dout   = cs ? dout_mux : 8'h00;
  assign irq_n  = irq_n_q;
  assign pa_out = ora_q;
  assign pa_oe  = ddra_q;

`ifdef VIA_PB7_EN
  logic pb7_q, pb7_d;

  // Free-run toggles PB7 each underflow; one-shot raises it on the armed underflow.
  always_comb begin
    pb7_d = pb7_q;
    if (wr_t1ch)    pb7_d = 1'b0;
    else if (t1_uf) pb7_d = acr_q[ACR_T1_FREERUN] ? ~pb7_q : 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pb7_q <= 1'b0;
    else          pb7_q <= pb7_d;
  end

  assign pb_out = acr_q[ACR_PB7_EN] ? {pb7_q, orb_q[6:0]} : orb_q;
  assign pb_oe  = acr_q[ACR_PB7_EN] ? {1'b1, ddrb_q[6:0]} : ddrb_q;
`else
  assign pb_out = orb_q;
  assign pb_oe  = ddrb_q;
`endif

endmodule

// File: tb/tb_via_timer_lite.sv
// Directed bench for via_timer_lite: one instance at TICK_DIV=1, one at TICK_DIV=4.
module tb_via_timer_lite;

  logic       clk, reset_n, cs1, cs4, we;
  logic [3:0] addr;
  logic [7:0] din, pa_in, pb_in;
  logic [7:0] dout1, pa_out1, pa_oe1, pb_out1, pb_oe1;
  logic [7:0] dout4, pa_out4, pa_oe4, pb_out4, pb_oe4;
  logic       irq_n1, irq_n4;

  int n_tests = 0;
  int n_fail  = 0;

  via_timer_lite #(.TICK_DIV(1)) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs1), .we(we), .addr(addr), .din(din),
    .dout(dout1), .irq_n(irq_n1), .pa_in(pa_in), .pa_out(pa_out1), .pa_oe(pa_oe1),
    .pb_in(pb_in), .pb_out(pb_out1), .pb_oe(pb_oe1)
  );

  via_timer_lite #(.TICK_DIV(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .cs(cs4), .we(we), .addr(addr), .din(din),
    .dout(dout4), .irq_n(irq_n4), .pa_in(pa_in), .pa_out(pa_out4), .pa_oe(pa_oe4),
    .pb_in(pb_in), .pb_out(pb_out4), .pb_oe(pb_oe4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wr(input bit u4, input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    cs1 = !u4; cs4 = u4; we = 1'b1; addr = a; din = d;
    @(posedge clk); #1;
    cs1 = 1'b0; cs4 = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input bit u4, input logic [3:0] a, output logic [7:0] v);
    @(negedge clk);
    cs1 = !u4; cs4 = u4; we = 1'b0; addr = a;
    #1 v = u4 ? dout4 : dout1;
    @(posedge clk); #1;
    cs1 = 1'b0; cs4 = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] v;
    reset_n = 1'b0; cs1 = 0; cs4 = 0; we = 0; addr = 4'h0; din = 8'h00;
    pa_in = 8'h00; pb_in = 8'h00;
    repeat (2) @(posedge clk); #1;
    n_tests++;
    if ({dout1, pa_out1, pa_oe1, pb_out1, pb_oe1} !== 40'h0) begin
      n_fail++; $display("FAIL reset_outputs1: got %h expected 0", {dout1, pa_out1, pa_oe1, pb_out1, pb_oe1});
    end
    n_tests++;
    if ({dout4, pa_out4, pa_oe4, pb_out4, pb_oe4} !== 40'h0) begin
      n_fail++; $display("FAIL reset_outputs4: got %h expected 0", {dout4, pa_out4, pa_oe4, pb_out4, pb_oe4});
    end
    n_tests++;
    if ({irq_n1, irq_n4} !== 2'b11) begin
      n_fail++; $display("FAIL reset_irq_n: got %b expected 11", {irq_n1, irq_n4});
    end
    @(negedge clk); reset_n = 1'b1;
    rd(0, 4'hE, v);
    n_tests++;
    if (v !== 8'h80) begin n_fail++; $display("FAIL reset_ier1: got %h expected 80", v); end
    rd(1, 4'hE, v);
    n_tests++;
    if (v !== 8'h80) begin n_fail++; $display("FAIL reset_ier4: got %h expected 80", v); end
    rd(0, 4'hD, v);
    n_tests++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL reset_ifr: got %h expected 00", v); end
  endtask

  task automatic test_t1_oneshot;
    logic [7:0] v;
    int n;
    bit seen;
    wr(0, 4'hE, 8'hC0);
    wr(0, 4'h4, 8'h05);
    wr(0, 4'h5, 8'h00);
    cs1 = 1'b1; we = 1'b0; addr = 4'h4;
    #1;
    n_tests++;
    if (dout1 !== 8'h05) begin n_fail++; $display("FAIL t1_count_load: got %h expected 05", dout1); end
    addr = 4'hD;
    n = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      @(posedge clk); #1;
      if (dout1[6]) n = i;
    end
    n_tests++;
    if (n != 6) begin n_fail++; $display("FAIL t1_oneshot_delay: got %0d cycles expected 6", n); end
    n_tests++;
    if ({dout1[7], irq_n1} !== 2'b11) begin
      n_fail++; $display("FAIL t1_ifr7_irq_pre: got %b expected 11", {dout1[7], irq_n1});
    end
    @(posedge clk); #1;
    n_tests++;
    if (irq_n1 !== 1'b0) begin n_fail++; $display("FAIL t1_irq_low: got %b expected 0", irq_n1); end
    cs1 = 1'b0;
    wr(0, 4'hD, 8'h40);
    cs1 = 1'b1; addr = 4'hD;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (dout1[6]) seen = 1;
    end
    cs1 = 1'b0;
    n_tests++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL t1_no_second_set: got %b expected 0", seen); end
    n_tests++;
    if (irq_n1 !== 1'b1) begin n_fail++; $display("FAIL t1_irq_release: got %b expected 1", irq_n1); end
    rd(0, 4'h5, v);
    n_tests++;
    if (v !== 8'hFF) begin n_fail++; $display("FAIL t1_count_hi_after: got %h expected FF", v); end
  endtask

  task automatic test_t1_freerun;
    int k;
    logic exp_pb7, exp_oe7;
    wr(0, 4'hB, 8'hC0);
    wr(0, 4'h4, 8'h03);
    wr(0, 4'h5, 8'h00);
    cs1 = 1'b1; we = 1'b0; addr = 4'hD;
    k = 0;
    for (int c = 1; c <= 22; c++) begin
      @(posedge clk); #1;
      if (addr == 4'hD && dout1[6]) begin
        k++;
        n_tests++;
        if (c != 4 * k) begin n_fail++; $display("FAIL t1_fr_period: got cycle %0d expected %0d", c, 4 * k); end
`ifdef VIA_PB7_EN
        exp_pb7 = k[0]; exp_oe7 = 1'b1;
`else
        exp_pb7 = 1'b0; exp_oe7 = 1'b0;
`endif
        n_tests++;
        if ({pb_out1[7], pb_oe1[7]} !== {exp_pb7, exp_oe7}) begin
          n_fail++; $display("FAIL t1_fr_pb7: got %b expected %b", {pb_out1[7], pb_oe1[7]}, {exp_pb7, exp_oe7});
        end
        addr = 4'h4;
      end else begin
        addr = 4'hD;
      end
    end
    cs1 = 1'b0;
    n_tests++;
    if (k != 5) begin n_fail++; $display("FAIL t1_fr_count: got %0d underflows expected 5", k); end
  endtask

  task automatic test_collision;
    int n;
    wr(0, 4'hB, 8'h00);
    wr(0, 4'hD, 8'h7F);
    wr(0, 4'h4, 8'h03);
    wr(0, 4'h5, 8'h00);
    @(negedge clk);
    cs1 = 1'b1; we = 1'b1; addr = 4'hD; din = 8'h40;
    repeat (4) @(posedge clk);
    #1 we = 1'b0;
    #1;
    n_tests++;
    if (dout1[6] !== 1'b1) begin n_fail++; $display("FAIL collision_set_wins: got %b expected 1", dout1[6]); end
    cs1 = 1'b0;
    wr(0, 4'hD, 8'h7F);
    wr(0, 4'h4, 8'h03);
    wr(0, 4'h5, 8'h00);
    repeat (3) @(posedge clk);
    wr(0, 4'h5, 8'h00);
    cs1 = 1'b1; addr = 4'hD;
    #1;
    n_tests++;
    if (dout1[6] !== 1'b0) begin n_fail++; $display("FAIL load_wins_flag: got %b expected 0", dout1[6]); end
    addr = 4'h4;
    #1;
    n_tests++;
    if (dout1 !== 8'h03) begin n_fail++; $display("FAIL load_wins_count: got %h expected 03", dout1); end
    addr = 4'hD;
    n = 0;
    for (int i = 1; i <= 10 && n == 0; i++) begin
      @(posedge clk); #1;
      if (dout1[6]) n = i;
    end
    cs1 = 1'b0;
    n_tests++;
    if (n != 4) begin n_fail++; $display("FAIL load_wins_rearm: got %0d cycles expected 4", n); end
    wr(0, 4'hD, 8'h7F);
  endtask

  task automatic test_t2_div4;
    logic [7:0] v;
    int n;
    wr(1, 4'hE, 8'hA0);
    wr(1, 4'h8, 8'h02);
    wr(1, 4'h9, 8'h00);
    cs4 = 1'b1; we = 1'b0; addr = 4'hD;
    n = 0;
    for (int i = 1; i <= 30 && n == 0; i++) begin
      @(posedge clk); #1;
      if (dout4[5]) n = i;
    end
    n_tests++;
    if (n < 9 || n > 12) begin n_fail++; $display("FAIL t2_delay: got %0d cycles expected 9..12", n); end
    n_tests++;
    if (dout4[7] !== 1'b1) begin n_fail++; $display("FAIL t2_ifr7: got %b expected 1", dout4[7]); end
    @(posedge clk); #1;
    n_tests++;
    if (irq_n4 !== 1'b0) begin n_fail++; $display("FAIL t2_irq_low: got %b expected 0", irq_n4); end
    cs4 = 1'b0;
    wr(1, 4'hD, 8'h20);
    rd(1, 4'hD, v);
    n_tests++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL t2_ifr_clear: got %h expected 00", v); end
    n_tests++;
    if (irq_n4 !== 1'b1) begin n_fail++; $display("FAIL t2_irq_high: got %b expected 1", irq_n4); end
    rd(1, 4'h9, v);
    n_tests++;
    if (v !== 8'hFF) begin n_fail++; $display("FAIL t2_count_hi: got %h expected FF", v); end
  endtask

  task automatic test_ports;
    logic [7:0] v;
    wr(0, 4'h2, 8'h0F);
    wr(0, 4'h0, 8'hA5);
    pb_in = 8'h3C;
    rd(0, 4'h0, v);
    n_tests++;
    if (v !== 8'h35) begin n_fail++; $display("FAIL portb_read: got %h expected 35", v); end
    n_tests++;
    if ({pb_out1, pb_oe1} !== 16'hA50F) begin
      n_fail++; $display("FAIL portb_pins: got %h expected A50F", {pb_out1, pb_oe1});
    end
    wr(0, 4'h3, 8'hFF);
    wr(0, 4'h1, 8'h81);
    pa_in = 8'h5A;
    n_tests++;
    if ({pa_out1, pa_oe1} !== 16'h81FF) begin
      n_fail++; $display("FAIL porta_pins: got %h expected 81FF", {pa_out1, pa_oe1});
    end
    rd(0, 4'h1, v);
    n_tests++;
    if (v !== 8'h5A) begin n_fail++; $display("FAIL porta_read: got %h expected 5A", v); end
    rd(0, 4'hF, v);
    n_tests++;
    if (v !== 8'h5A) begin n_fail++; $display("FAIL porta_alias: got %h expected 5A", v); end
    wr(0, 4'h7, 8'h12);
    rd(0, 4'h7, v);
    n_tests++;
    if (v !== 8'h12) begin n_fail++; $display("FAIL t1_latch_hi: got %h expected 12", v); end
    rd(0, 4'h6, v);
    n_tests++;
    if (v !== 8'h03) begin n_fail++; $display("FAIL t1_latch_lo: got %h expected 03", v); end
    wr(0, 4'hA, 8'h55);
    rd(0, 4'hA, v);
    n_tests++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL sr_read: got %h expected 00", v); end
    wr(0, 4'hC, 8'h3C);
    rd(0, 4'hC, v);
    n_tests++;
    if (v !== 8'h3C) begin n_fail++; $display("FAIL pcr_read: got %h expected 3C", v); end
  endtask

  task automatic test_reset_midcount;
    logic [7:0] v;
    wr(0, 4'h4, 8'h10);
    wr(0, 4'h5, 8'h00);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({dout1, pa_out1, pa_oe1, pb_out1, pb_oe1} !== 40'h0) begin
      n_fail++; $display("FAIL midreset_outputs: got %h expected 0", {dout1, pa_out1, pa_oe1, pb_out1, pb_oe1});
    end
    n_tests++;
    if ({irq_n1, irq_n4} !== 2'b11) begin
      n_fail++; $display("FAIL midreset_irq_n: got %b expected 11", {irq_n1, irq_n4});
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    rd(0, 4'hE, v);
    n_tests++;
    if (v !== 8'h80) begin n_fail++; $display("FAIL midreset_ier: got %h expected 80", v); end
    repeat (20) @(posedge clk);
    rd(0, 4'hD, v);
    n_tests++;
    if (v !== 8'h00) begin n_fail++; $display("FAIL midreset_disarmed: got %h expected 00", v); end
  endtask

  initial begin
    test_reset();
    test_t1_oneshot();
    test_t1_freerun();
    test_collision();
    test_t2_div4();
    test_ports();
    test_reset_midcount();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
